// File: rtl/memory_stage_if.sv
// Bundles the upstream, writeback and data-memory signals of the memory stage.
// The stage connects through the slave modport; its environment uses master.
interface memory_stage_if;
  // upstream (from execute)
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [5:0]  instr_id;
  logic [4:0]  rd_addr;
  logic [31:0] exec_output;
  logic [31:0] mem_addr;
  logic [31:0] rs2;
  // downstream (to writeback)
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        misaligned_err;
  // data memory
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport slave (
    input  in_valid, opcode, instr_id, rd_addr, exec_output, mem_addr, rs2,
           out_ready, dmem_ready, dmem_rdata,
    output in_ready, out_valid, wb_rd_addr, wb_data, wb_we, misaligned_err,
           dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
  );

  modport master (
    output in_valid, opcode, instr_id, rd_addr, exec_output, mem_addr, rs2,
           out_ready, dmem_ready, dmem_rdata,
    input  in_ready, out_valid, wb_rd_addr, wb_data, wb_we, misaligned_err,
           dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
  );
endinterface

// File: rtl/memory_stage.sv
// RV32I memory stage: passes ALU results through in one cycle, performs
// aligned loads/stores over a ready-handshaked data-memory port, and flags
// misaligned accesses without touching memory.
module memory_stage (
  input  logic          clk,
  input  logic          rst,
  memory_stage_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEM  = 1'b1;

  localparam logic [5:0] ID_LB  = 6'h13;
  localparam logic [5:0] ID_LH  = 6'h14;
  localparam logic [5:0] ID_LW  = 6'h15;
  localparam logic [5:0] ID_LBU = 6'h16;
  localparam logic [5:0] ID_LHU = 6'h17;
  localparam logic [5:0] ID_SB  = 6'h18;
  localparam logic [5:0] ID_SH  = 6'h19;
  localparam logic [5:0] ID_SW  = 6'h1A;

  logic [0:0]  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        mis_err_q, mis_err_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
  // in-flight access context needed to shape the load result
  logic [5:0]  pend_id_q, pend_id_d;
  logic [1:0]  pend_lo_q, pend_lo_d;
  logic [4:0]  pend_rd_q, pend_rd_d;

  logic        accept, is_mem, is_load, is_half, is_word, misaligned, alu_we;
  logic [31:0] ld_shift, ld_data;

  // Ready only in IDLE with a free (or draining) output register, never in reset
  assign bus.in_ready = !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Decode the incoming entry
  always_comb begin
    is_mem     = (bus.instr_id >= ID_LB) && (bus.instr_id <= ID_SW);
    is_load    = (bus.instr_id >= ID_LB) && (bus.instr_id <= ID_LHU);
    is_half    = (bus.instr_id == ID_LH) || (bus.instr_id == ID_LHU) || (bus.instr_id == ID_SH);
    is_word    = (bus.instr_id == ID_LW) || (bus.instr_id == ID_SW);
    misaligned = (is_half && bus.mem_addr[0]) || (is_word && (bus.mem_addr[1:0] != 2'b00));
    alu_we     = ((bus.opcode == 7'b0110011) || (bus.opcode == 7'b0010011) ||
                  (bus.opcode == 7'b1101111) || (bus.opcode == 7'b1100111) ||
                  (bus.opcode == 7'b0110111)) && (bus.rd_addr != 5'd0);
  end

  // Align the returned word so the addressed byte/half sits at bit 0, then extend
  always_comb begin
    ld_shift = bus.dmem_rdata >> {pend_lo_q, 3'b000};
    case (pend_id_q)
      ID_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      ID_LBU:  ld_data = {24'd0, ld_shift[7:0]};
      ID_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      ID_LHU:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Next-state: output register handshake, entry acceptance and memory completion
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    wb_data_d    = wb_data_q;
    wb_we_d      = wb_we_q;
    wb_rd_addr_d = wb_rd_addr_q;
    mis_err_d    = mis_err_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    pend_id_d    = pend_id_q;
    pend_lo_d    = pend_lo_q;
    pend_rd_d    = pend_rd_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
      wb_data_d    = 32'd0;
      wb_we_d      = 1'b0;
      wb_rd_addr_d = 5'd0;
      mis_err_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            out_valid_d  = 1'b1;
            wb_data_d    = bus.exec_output;
            wb_we_d      = alu_we;
            wb_rd_addr_d = bus.rd_addr;
            mis_err_d    = 1'b0;
          end else if (misaligned) begin
            out_valid_d  = 1'b1;
            wb_data_d    = 32'd0;
            wb_we_d      = 1'b0;
            wb_rd_addr_d = bus.rd_addr;
            mis_err_d    = 1'b1;
          end else begin
            state_d      = S_MEM;
            dmem_req_d   = 1'b1;
            dmem_we_d    = !is_load;
            dmem_addr_d  = {bus.mem_addr[31:2], 2'b00};
            pend_id_d    = bus.instr_id;
            pend_lo_d    = bus.mem_addr[1:0];
            pend_rd_d    = bus.rd_addr;
            case (bus.instr_id)
              ID_SB: begin
                dmem_wstrb_d = 4'b0001 << bus.mem_addr[1:0];
                dmem_wdata_d = {4{bus.rs2[7:0]}};
              end
              ID_SH: begin
                dmem_wstrb_d = 4'b0011 << bus.mem_addr[1:0];
                dmem_wdata_d = {2{bus.rs2[15:0]}};
              end
              ID_SW: begin
                dmem_wstrb_d = 4'b1111;
                dmem_wdata_d = bus.rs2;
              end
              default: begin
                dmem_wstrb_d = 4'b0000;
                dmem_wdata_d = 32'd0;
              end
            endcase
          end
        end
      end
      default: begin
        if (bus.dmem_ready) begin
          state_d      = S_IDLE;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_wstrb_d = 4'b0000;
          out_valid_d  = 1'b1;
          wb_rd_addr_d = pend_rd_q;
          mis_err_d    = 1'b0;
          if (pend_id_q <= ID_LHU) begin
            wb_data_d = ld_data;
            wb_we_d   = (pend_rd_q != 5'd0);
          end else begin
            wb_data_d = 32'd0;
            wb_we_d   = 1'b0;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      wb_data_q    <= 32'd0;
      wb_we_q      <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      mis_err_q    <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wstrb_q <= 4'd0;
      pend_id_q    <= 6'd0;
      pend_lo_q    <= 2'd0;
      pend_rd_q    <= 5'd0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      wb_data_q    <= wb_data_d;
      wb_we_q      <= wb_we_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      mis_err_q    <= mis_err_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      pend_id_q    <= pend_id_d;
      pend_lo_q    <= pend_lo_d;
      pend_rd_q    <= pend_rd_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.wb_we          = wb_we_q;
  assign bus.wb_rd_addr     = wb_rd_addr_q;
  assign bus.misaligned_err = mis_err_q;
  assign bus.dmem_req       = dmem_req_q;
  assign bus.dmem_we        = dmem_we_q;
  assign bus.dmem_addr      = dmem_addr_q;
  assign bus.dmem_wdata     = dmem_wdata_q;
  assign bus.dmem_wstrb     = dmem_wstrb_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a transaction-level model predicts the
// stage's outputs every cycle, and literal checks pin the key scenarios.
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if bus();
  memory_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic we; logic mis; logic [31:0] data; } res_t;

  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  function automatic int unsigned acc_size(input logic [5:0] id);
    case (id)
      6'h13, 6'h16, 6'h18: return 1;
      6'h14, 6'h17, 6'h19: return 2;
      6'h15, 6'h1A:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [5:0] id);
    return (id >= 6'h13) && (id <= 6'h17);
  endfunction

  function automatic res_t load_result(input logic [5:0] id, input logic [31:0] addr,
                                       input logic [31:0] rdata);
    logic [31:0] v;
    res_t r;
    v = rdata >> (8 * int'(addr[1:0]));
    case (acc_size(id))
      1:       v = (id == 6'h13) ? 32'($signed(v[7:0]))  : {24'd0, v[7:0]};
      2:       v = (id == 6'h14) ? 32'($signed(v[15:0])) : {16'd0, v[15:0]};
      default: v = rdata;
    endcase
    r.data = v; r.we = 1'b0; r.mis = 1'b0;
    return r;
  endfunction

  bit          started = 0;
  logic        m_valid = 0, m_we = 0, m_mis = 0, m_busy = 0;
  logic [31:0] m_data = 0;
  logic [4:0]  m_rd = 0;
  logic [5:0]  p_id = 0;
  logic [31:0] p_addr = 0, p_rs2 = 0;
  logic [4:0]  p_rd = 0;

  // Model advances one transaction step per edge from the sampled inputs
  always @(posedge clk) begin
    bit          acc;
    int unsigned sz;
    res_t        r;
    started = 1;
    if (rst) begin
      m_valid = 0; m_busy = 0; m_we = 0; m_mis = 0; m_data = 0; m_rd = 0;
    end else begin
      acc = bus.in_valid && !m_busy && (!m_valid || bus.out_ready);
      if (m_valid && bus.out_ready) m_valid = 0;
      if (m_busy && bus.dmem_ready) begin
        m_busy = 0; m_valid = 1; m_rd = p_rd; m_mis = 0;
        if (is_ld(p_id)) begin
          r = load_result(p_id, p_addr, bus.dmem_rdata);
          m_data = r.data; m_we = (p_rd != 0);
        end else begin
          m_data = 0; m_we = 0;
        end
      end else if (acc) begin
        sz = acc_size(bus.instr_id);
        if (sz == 0) begin
          m_valid = 1; m_data = bus.exec_output; m_rd = bus.rd_addr; m_mis = 0;
          m_we = (bus.opcode inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111})
                 && (bus.rd_addr != 0);
        end else if ((int'(bus.mem_addr[1:0]) % sz) != 0) begin
          m_valid = 1; m_data = 0; m_we = 0; m_mis = 1; m_rd = bus.rd_addr;
        end else begin
          m_busy = 1; p_id = bus.instr_id; p_addr = bus.mem_addr;
          p_rs2 = bus.rs2; p_rd = bus.rd_addr;
        end
      end
    end
  end

  // Every cycle: compare DUT against the model
  always @(negedge clk) begin
    int unsigned sz;
    logic [3:0]  strb;
    logic [31:0] wd;
    if (started) begin
      chk("in_ready", bus.in_ready, !rst && !m_busy && (!m_valid || bus.out_ready));
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("wb_data", bus.wb_data, m_data);
        chk("wb_we", bus.wb_we, m_we);
        chk("wb_rd_addr", bus.wb_rd_addr, m_rd);
        chk("misaligned_err", bus.misaligned_err, m_mis);
      end
      chk("dmem_req", bus.dmem_req, m_busy);
      if (m_busy) begin
        sz   = acc_size(p_id);
        strb = is_ld(p_id) ? 4'b0000 : 4'(((1 << sz) - 1) << p_addr[1:0]);
        wd   = (sz == 1) ? {4{p_rs2[7:0]}} : (sz == 2) ? {2{p_rs2[15:0]}} : p_rs2;
        chk("dmem_addr", bus.dmem_addr, p_addr & ~32'h3);
        chk("dmem_we", bus.dmem_we, !is_ld(p_id));
        chk("dmem_wstrb", bus.dmem_wstrb, strb);
        if (!is_ld(p_id)) chk("dmem_wdata", bus.dmem_wdata, wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one entry and hold it until accepted; returns in the cycle after acceptance
  task automatic send(input logic [6:0] op, input logic [5:0] id, input logic [4:0] rd,
                      input logic [31:0] ex, input logic [31:0] addr, input logic [31:0] d2);
    bit ok;
    ok = 0;
    bus.opcode = op; bus.instr_id = id; bus.rd_addr = rd;
    bus.exec_output = ex; bus.mem_addr = addr; bus.rs2 = d2; bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Hold dmem_ready low for delay-1 cycles, then high for one; capture request fields
  task automatic mem_resp(input int delay, input logic [31:0] rdata, output int req_cycles,
                          output logic [31:0] a, output logic we, output logic [3:0] s,
                          output logic [31:0] wd);
    req_cycles = 0;
    bus.dmem_rdata = rdata;
    for (int d = 1; d <= delay; d++) begin
      if (d == delay) bus.dmem_ready = 1'b1;
      @(negedge clk);
      if (bus.dmem_req) req_cycles++;
      if (d == 1) begin a = bus.dmem_addr; we = bus.dmem_we; s = bus.dmem_wstrb; wd = bus.dmem_wdata; end
      step();
    end
    bus.dmem_ready = 1'b0;
  endtask

  task automatic check_wb(input string name, input logic [31:0] data, input logic we,
                          input logic mis);
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk({name, "_data"}, bus.wb_data, data);
    chk({name, "_we"}, bus.wb_we, we);
    chk({name, "_mis"}, bus.misaligned_err, mis);
    step();
  endtask

  // Memory access with literal expectations on request and result
  task automatic mem_case(input string name, input logic [5:0] id, input logic [31:0] addr,
                          input logic [31:0] d2, input int delay, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wd, input logic [31:0] e_data,
                          input logic e_we);
    int          rc;
    logic [31:0] a, wd;
    logic        we;
    logic [3:0]  s;
    send(is_ld(id) ? OP_LD : OP_ST, id, 5'd9, 32'h0, addr, d2);
    mem_resp(delay, rdata, rc, a, we, s, wd);
    chk({name, "_req_cycles"}, rc, delay);
    chk({name, "_addr"}, a, e_addr);
    chk({name, "_dmem_we"}, we, !is_ld(id));
    chk({name, "_wstrb"}, s, e_strb);
    if (!is_ld(id)) chk({name, "_wdata"}, wd, e_wd);
    check_wb(name, e_data, e_we, 1'b0);
  endtask

  initial begin
    bus.in_valid = 0; bus.opcode = 0; bus.instr_id = 0; bus.rd_addr = 0;
    bus.exec_output = 0; bus.mem_addr = 0; bus.rs2 = 0;
    bus.out_ready = 1; bus.dmem_ready = 0; bus.dmem_rdata = 0;

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    step();
    rst = 1'b0;
    step();

    // ALU pass-through
    send(OP_ADD, 6'h01, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    @(negedge clk);
    chk("add_rd", bus.wb_rd_addr, 5'd5);
    step();
    check_wb_after_add: begin end
    send(OP_ADD, 6'h01, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    check_wb("add", 32'h1234, 1'b1, 1'b0);
    send(OP_ADD, 6'h01, 5'd0, 32'h0000_1234, 32'h0, 32'h0);
    check_wb("add_rd0", 32'h1234, 1'b0, 1'b0);
    send(7'b1101111, 6'h02, 5'd1, 32'h0000_0044, 32'h0, 32'h0);
    check_wb("jal", 32'h44, 1'b1, 1'b0);
    send(7'b1100011, 6'h03, 5'd3, 32'h0000_0001, 32'h0, 32'h0);
    check_wb("branch", 32'h1, 1'b0, 1'b0);

    // loads
    mem_case("lb",  6'h13, 32'h103, 32'h0, 3, 32'h80AA_BBCC, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);
    mem_case("lbu", 6'h16, 32'h103, 32'h0, 3, 32'h80AA_BBCC, 32'h100, 4'b0000, 32'h0, 32'h0000_0080, 1'b1);
    mem_case("lh",  6'h14, 32'h102, 32'h0, 1, 32'h80AA_BBCC, 32'h100, 4'b0000, 32'h0, 32'hFFFF_80AA, 1'b1);
    mem_case("lhu", 6'h17, 32'h100, 32'h0, 2, 32'h80AA_BBCC, 32'h100, 4'b0000, 32'h0, 32'h0000_BBCC, 1'b1);
    mem_case("lw",  6'h15, 32'h300, 32'h0, 1, 32'hDEAD_BEEF, 32'h300, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1);

    // stores
    mem_case("sh", 6'h19, 32'h202, 32'h1234_ABCD, 1, 32'h0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
    mem_case("sb", 6'h18, 32'h101, 32'h0000_0055, 2, 32'h0, 32'h100, 4'b0010, 32'h5555_5555, 32'h0, 1'b0);
    mem_case("sw", 6'h1A, 32'h40C, 32'hCAFE_F00D, 1, 32'h0, 32'h40C, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);

    // misaligned accesses never reach memory
    send(OP_LD, 6'h15, 5'd4, 32'h0, 32'h301, 32'h0);
    @(negedge clk);
    chk("lw_mis_req", bus.dmem_req, 1'b0);
    step();
    send(OP_LD, 6'h15, 5'd4, 32'h0, 32'h301, 32'h0);
    check_wb("lw_mis", 32'h0, 1'b0, 1'b1);
    send(OP_ST, 6'h19, 5'd0, 32'h0, 32'h203, 32'h1111_2222);
    check_wb("sh_mis", 32'h0, 1'b0, 1'b1);

    // backpressure then same-edge handoff
    bus.out_ready = 1'b0;
    send(OP_ADD, 6'h01, 5'd7, 32'h0000_AAAA, 32'h0, 32'h0);
    bus.opcode = OP_ADD; bus.instr_id = 6'h01; bus.rd_addr = 5'd8;
    bus.exec_output = 32'h0000_BBBB; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data", bus.wb_data, 32'h0000_AAAA);
      chk("bp_rd", bus.wb_rd_addr, 5'd7);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("handoff_valid", bus.out_valid, 1'b1);
    chk("handoff_data", bus.wb_data, 32'h0000_BBBB);
    chk("handoff_rd", bus.wb_rd_addr, 5'd8);
    step();

    // reset during an outstanding access
    send(OP_LD, 6'h15, 5'd6, 32'h0, 32'h400, 32'h0);
    @(negedge clk);
    chk("rstmem_req_before", bus.dmem_req, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmem_in_ready", bus.in_ready, 1'b0);
    step();
    rst = 1'b0;
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("rstmem_req_after", bus.dmem_req, 1'b0);
    chk("rstmem_in_ready_after", bus.in_ready, 1'b1);
    step();
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    chk("rstmem_out_valid", bus.out_valid, 1'b0);
    chk("rstmem_req_late", bus.dmem_req, 1'b0);
    step();

    // recovers to normal operation
    send(OP_ADD, 6'h01, 5'd2, 32'h0000_0777, 32'h0, 32'h0);
    check_wb("post_rst_add", 32'h777, 1'b1, 1'b0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
